// File: rtl/generador_selector_pkg.sv
`default_nettype none
// ============================================================================
// Module : generador_selector_pkg
// Brief  : States, code constants and next-code function for generador_selector.
//          Build option: GENERADOR_SELECTOR_GRAY_EN selects Gray code order.
// Rev    : 1.0
// ============================================================================
package generador_selector_pkg;

    typedef enum logic [0:0] {
        REPOSO   = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    typedef logic [1:0] codigo_t;

    localparam codigo_t c_PRIMER_CODIGO  = 2'b00;
    localparam codigo_t c_ULTIMO_BINARIO = 2'b11;
    localparam codigo_t c_ULTIMO_GRAY    = 2'b10;

`ifdef GENERADOR_SELECTOR_GRAY_EN
    localparam codigo_t c_ULTIMO_CODIGO = c_ULTIMO_GRAY;
`else
    localparam codigo_t c_ULTIMO_CODIGO = c_ULTIMO_BINARIO;
`endif

    function automatic codigo_t siguiente_codigo(input codigo_t actual);
        codigo_t siguiente;
`ifdef GENERADOR_SELECTOR_GRAY_EN
        // One bit toggles per step so the mux never sees a transient code
        case (actual)
            2'b00:   siguiente = 2'b01;
            2'b01:   siguiente = 2'b11;
            2'b11:   siguiente = 2'b10;
            default: siguiente = 2'b00;
        endcase
`else
        siguiente = actual + 2'b01;
`endif
        return siguiente;
    endfunction

endpackage
`default_nettype wire

// File: rtl/generador_selector_if.sv
`default_nettype none
// ============================================================================
// Module : generador_selector_if
// Brief  : Control and status bundle between a controller and generador_selector.
// Rev    : 1.0
// ============================================================================
interface generador_selector_if
    import generador_selector_pkg::*;
#(
    parameter int ANCHO_PERIODO = 8
);
    logic                     Inicio;
    logic                     Continuo;
    logic                     Detener;
    logic [ANCHO_PERIODO-1:0] Periodo;
    codigo_t                  Selector;
    logic                     Cambio;
    logic                     Ocupado;
    logic                     Fin;

    modport master (
        output Inicio, Continuo, Detener, Periodo,
        input  Selector, Cambio, Ocupado, Fin
    );

    modport slave (
        input  Inicio, Continuo, Detener, Periodo,
        output Selector, Cambio, Ocupado, Fin
    );
endinterface
`default_nettype wire

// File: rtl/generador_selector_contador_permanencia.sv
`default_nettype none
// ============================================================================
// Module : contador_permanencia
// Brief  : Loadable down-counter; Terminal flags a count of one.
// Rev    : 1.0
// ============================================================================
module contador_permanencia #(
    parameter int ANCHO_PERIODO = 8
) (
    input  wire logic                     Reloj,
    input  wire logic                     Reset,
    input  wire logic                     Cargar,
    input  wire logic                     Decrementar,
    input  wire logic [ANCHO_PERIODO-1:0] Valor,
    output      logic                     Terminal
);
    logic [ANCHO_PERIODO-1:0] r_cuenta_q;
    logic [ANCHO_PERIODO-1:0] w_cuenta_d;

    always_comb begin
        w_cuenta_d = r_cuenta_q;
        if (Cargar) begin
            w_cuenta_d = Valor;
        end else if (Decrementar && (r_cuenta_q != '0)) begin
            w_cuenta_d = r_cuenta_q - ANCHO_PERIODO'(1);
        end
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            r_cuenta_q <= '0;
        end else begin
            r_cuenta_q <= w_cuenta_d;
        end
    end

    assign Terminal = (r_cuenta_q == ANCHO_PERIODO'(1));
endmodule
`default_nettype wire

// File: rtl/generador_selector.sv
`default_nettype none
// ============================================================================
// Module : generador_selector
// Brief  : Timed sequencer stepping the 2-bit mux Selector through a code list.
//          Build option: GENERADOR_SELECTOR_GRAY_EN selects Gray code order.
// Rev    : 1.0
// ============================================================================
module generador_selector
    import generador_selector_pkg::*;
#(
    parameter int ANCHO_PERIODO = 8
) (
    input wire logic          Reloj,
    input wire logic          Reset,
    generador_selector_if.slave bus
);
    estado_t                  r_estado_q,   w_estado_d;
    codigo_t                  r_selector_q, w_selector_d;
    logic                     r_cambio_q,   w_cambio_d;
    logic                     r_ocupado_q,  w_ocupado_d;
    logic                     r_fin_q,      w_fin_d;
    logic                     r_continuo_q, w_continuo_d;
    logic [ANCHO_PERIODO-1:0] r_periodo_q,  w_periodo_d;

    logic                     w_cargar;
    logic                     w_decrementar;
    logic [ANCHO_PERIODO-1:0] w_valor;
    logic                     w_terminal;

    contador_permanencia #(
        .ANCHO_PERIODO (ANCHO_PERIODO)
    ) u_contador (
        .Reloj       (Reloj),
        .Reset       (Reset),
        .Cargar      (w_cargar),
        .Decrementar (w_decrementar),
        .Valor       (w_valor),
        .Terminal    (w_terminal)
    );

    always_comb begin
        w_estado_d    = r_estado_q;
        w_selector_d  = r_selector_q;
        w_ocupado_d   = r_ocupado_q;
        w_continuo_d  = r_continuo_q;
        w_periodo_d   = r_periodo_q;
        w_cambio_d    = 1'b0;
        w_fin_d       = 1'b0;
        w_cargar      = 1'b0;
        w_decrementar = 1'b0;
        w_valor       = r_periodo_q;

        case (r_estado_q)
            REPOSO: begin
                if (bus.Inicio && !bus.Detener) begin
                    w_estado_d   = CONTANDO;
                    // A zero dwell would never reach terminal; run it as one cycle
                    w_periodo_d  = (bus.Periodo == '0) ? ANCHO_PERIODO'(1) : bus.Periodo;
                    w_continuo_d = bus.Continuo;
                    w_cargar     = 1'b1;
                    w_valor      = w_periodo_d;
                    w_selector_d = c_PRIMER_CODIGO;
                    w_ocupado_d  = 1'b1;
                end
            end
            CONTANDO: begin
                if (bus.Detener) begin
                    w_estado_d   = REPOSO;
                    w_selector_d = c_PRIMER_CODIGO;
                    w_ocupado_d  = 1'b0;
                end else if (!w_terminal) begin
                    w_decrementar = 1'b1;
                end else if (r_selector_q != c_ULTIMO_CODIGO) begin
                    w_selector_d = siguiente_codigo(r_selector_q);
                    w_cambio_d   = 1'b1;
                    w_cargar     = 1'b1;
                end else if (r_continuo_q) begin
                    w_selector_d = c_PRIMER_CODIGO;
                    w_cambio_d   = 1'b1;
                    w_cargar     = 1'b1;
                end else begin
                    w_estado_d   = REPOSO;
                    w_selector_d = c_PRIMER_CODIGO;
                    w_ocupado_d  = 1'b0;
                    w_fin_d      = 1'b1;
                end
            end
            default: begin
                w_estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            r_estado_q   <= REPOSO;
            r_selector_q <= c_PRIMER_CODIGO;
            r_cambio_q   <= 1'b0;
            r_ocupado_q  <= 1'b0;
            r_fin_q      <= 1'b0;
            r_continuo_q <= 1'b0;
            r_periodo_q  <= '0;
        end else begin
            r_estado_q   <= w_estado_d;
            r_selector_q <= w_selector_d;
            r_cambio_q   <= w_cambio_d;
            r_ocupado_q  <= w_ocupado_d;
            r_fin_q      <= w_fin_d;
            r_continuo_q <= w_continuo_d;
            r_periodo_q  <= w_periodo_d;
        end
    end

    assign bus.Selector = r_selector_q;
    assign bus.Cambio   = r_cambio_q;
    assign bus.Ocupado  = r_ocupado_q;
    assign bus.Fin      = r_fin_q;
endmodule
`default_nettype wire

// File: tb/tb_generador_selector.sv
`default_nettype none
// ============================================================================
// Module : tb_generador_selector
// Brief  : Self-checking bench for generador_selector (binary or Gray build).
// Rev    : 1.0
// ============================================================================
module tb_generador_selector;

    logic Reloj = 1'b0;
    logic Reset;
    always #5 Reloj = ~Reloj;

    generador_selector_if #(.ANCHO_PERIODO(8)) bus ();

    generador_selector #(.ANCHO_PERIODO(8)) dut (
        .Reloj (Reloj),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic       ini;
        logic       det;
        logic [7:0] per;
        int         idx;   // expected code position, -1 = idle
        logic       cambio;
        logic       fin;
    } vec_t;

    logic [1:0] seq [4];
    vec_t       tabla [14];
    int         total = 0;
    int         bad   = 0;
    int         fin_vistos;

    // reference model state
    int         m_run, m_e0, m_p, m_cont, m_c;
    logic [1:0] e_sel;
    logic       e_cambio, e_ocup, e_fin;

    task automatic chk(input string nombre, input int actual, input int esperado);
        total++;
        if (actual != esperado) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    task automatic cyc(input logic ini, input logic det, input logic cont,
                       input logic [7:0] per, input logic rst);
        bus.Inicio   = ini;
        bus.Detener  = det;
        bus.Continuo = cont;
        bus.Periodo  = per;
        Reset        = rst;
        @(posedge Reloj);
        #1;
    endtask

    task automatic chk_reposo(input string nombre);
        chk({nombre, "_sel"}, int'(bus.Selector), 0);
        chk({nombre, "_cambio"}, int'(bus.Cambio), 0);
        chk({nombre, "_ocupado"}, int'(bus.Ocupado), 0);
        chk({nombre, "_fin"}, int'(bus.Fin), 0);
    endtask

    // Expected outputs of cycle c from the timing rules: code k valid from E0+1+kP
    task automatic modelo(input logic rst, input logic ini, input logic det,
                          input logic cont, input logic [7:0] per, input int c);
        int d;
        e_sel = 2'b00; e_cambio = 1'b0; e_ocup = 1'b0; e_fin = 1'b0;
        if (rst) begin
            m_run = 0;
        end else if (m_run == 0) begin
            if (ini && !det) begin
                m_run  = 1;
                m_e0   = c - 1;
                m_p    = (per == 0) ? 1 : int'(per);
                m_cont = int'(cont);
                e_sel  = seq[0];
                e_ocup = 1'b1;
            end
        end else if (det) begin
            m_run = 0;
        end else begin
            d = c - m_e0 - 1;
            if (m_cont == 0 && d == 4 * m_p) begin
                m_run = 0;
                e_fin = 1'b1;
            end else begin
                e_sel    = seq[(d / m_p) % 4];
                e_cambio = (d % m_p == 0);
                e_ocup   = 1'b1;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef GENERADOR_SELECTOR_GRAY_EN
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
`else
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11;
`endif
        // one pass, P=3; Inicio repeated and Periodo changed mid-run must be ignored
        tabla[0]  = '{1'b1, 1'b0, 8'd3,  0, 1'b0, 1'b0};
        tabla[1]  = '{1'b0, 1'b0, 8'd3,  0, 1'b0, 1'b0};
        tabla[2]  = '{1'b1, 1'b0, 8'd3,  0, 1'b0, 1'b0};
        tabla[3]  = '{1'b0, 1'b0, 8'd7,  1, 1'b1, 1'b0};
        tabla[4]  = '{1'b0, 1'b0, 8'd7,  1, 1'b0, 1'b0};
        tabla[5]  = '{1'b0, 1'b0, 8'd7,  1, 1'b0, 1'b0};
        tabla[6]  = '{1'b0, 1'b0, 8'd7,  2, 1'b1, 1'b0};
        tabla[7]  = '{1'b0, 1'b0, 8'd7,  2, 1'b0, 1'b0};
        tabla[8]  = '{1'b0, 1'b0, 8'd7,  2, 1'b0, 1'b0};
        tabla[9]  = '{1'b0, 1'b0, 8'd7,  3, 1'b1, 1'b0};
        tabla[10] = '{1'b0, 1'b0, 8'd7,  3, 1'b0, 1'b0};
        tabla[11] = '{1'b0, 1'b0, 8'd7,  3, 1'b0, 1'b0};
        tabla[12] = '{1'b0, 1'b0, 8'd7, -1, 1'b0, 1'b1};
        tabla[13] = '{1'b0, 1'b0, 8'd7, -1, 1'b0, 1'b0};

        cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        chk_reposo("reset");

        for (int i = 0; i < 14; i++) begin
            cyc(tabla[i].ini, tabla[i].det, 1'b0, tabla[i].per, 1'b0);
            chk($sformatf("tab%0d_sel", i + 1), int'(bus.Selector),
                (tabla[i].idx < 0) ? 0 : int'(seq[tabla[i].idx]));
            chk($sformatf("tab%0d_cambio", i + 1), int'(bus.Cambio), int'(tabla[i].cambio));
            chk($sformatf("tab%0d_ocupado", i + 1), int'(bus.Ocupado), (tabla[i].idx < 0) ? 0 : 1);
            chk($sformatf("tab%0d_fin", i + 1), int'(bus.Fin), int'(tabla[i].fin));
        end

        // continuous, P=2: wrap to first code at cycle 9, never Fin
        fin_vistos = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(i == 0, 1'b0, 1'b1, 8'd2, 1'b0);
            fin_vistos += int'(bus.Fin);
            if (i + 1 == 7 || i + 1 == 8) chk("cont_last", int'(bus.Selector), int'(seq[3]));
            if (i + 1 == 9) begin
                chk("cont_wrap_sel", int'(bus.Selector), int'(seq[0]));
                chk("cont_wrap_cambio", int'(bus.Cambio), 1);
                chk("cont_wrap_ocupado", int'(bus.Ocupado), 1);
            end
        end
        chk("cont_no_fin", fin_vistos, 0);
        cyc(1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
        chk_reposo("cont_stop");

        // Periodo=0 behaves as one-cycle dwell
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("p0_c1", int'(bus.Selector), int'(seq[0]));
        for (int k = 1; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            chk($sformatf("p0_c%0d_sel", k + 1), int'(bus.Selector), int'(seq[k]));
            chk($sformatf("p0_c%0d_cambio", k + 1), int'(bus.Cambio), 1);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("p0_fin", int'(bus.Fin), 1);
        chk("p0_ocupado", int'(bus.Ocupado), 0);

        // Detener at cycle 5 of a P=3 run
        for (int i = 0; i <= 5; i++) cyc(i == 0, i == 5, 1'b0, 8'd3, 1'b0);
        chk_reposo("detener");

        // Reset at cycle 8 of a P=3 run with ignored restart/period change
        for (int i = 0; i < 8; i++) cyc(i == 0 || i == 2, 1'b0, 1'b0, (i >= 3) ? 8'd7 : 8'd3, 1'b0);
        chk("pre_reset_sel", int'(bus.Selector), int'(seq[2]));
        chk("pre_reset_ocupado", int'(bus.Ocupado), 1);
        cyc(1'b1, 1'b0, 1'b1, 8'd7, 1'b1);
        chk_reposo("reset_mid");

        // randomized run against the reference model
        m_run = 0;
        m_c   = 0;
        for (int i = 0; i < 2000; i++) begin
            logic       r_rst, r_ini, r_det, r_cont;
            logic [7:0] r_per;
            r_rst  = ($urandom % 100) == 0;
            r_ini  = ($urandom % 4) == 0;
            r_det  = ($urandom % 25) == 0;
            r_cont = $urandom % 2;
            r_per  = 8'($urandom_range(0, 4));
            cyc(r_ini, r_det, r_cont, r_per, r_rst);
            m_c++;
            modelo(r_rst, r_ini, r_det, r_cont, r_per, m_c);
            chk("rnd_sel", int'(bus.Selector), int'(e_sel));
            chk("rnd_cambio", int'(bus.Cambio), int'(e_cambio));
            chk("rnd_ocupado", int'(bus.Ocupado), int'(e_ocup));
            chk("rnd_fin", int'(bus.Fin), int'(e_fin));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
